// File: rtl/column_shift_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : column_shift_scheduler
// Brief   : Double-buffered column-shift key sequencer; one key byte per
//           column block, emitted one cycle after each accepted pixel.
// Revision: 1.0 - initial release
// ============================================================================
module column_shift_scheduler #(
  parameter int NUM_BLOCKS = 10,
  parameter int BLOCK_W    = 64,
  parameter int H_ACTIVE   = 640
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [79:0] column_shift,
  input  logic        key_load,
  input  logic        enable,
  input  logic        frame_start,
  input  logic        line_start,
  input  logic        pixel_valid,
  output logic [7:0]  shift_amt,
  output logic        shift_valid,
  output logic [3:0]  block_idx,
  output logic        key_pending,
  output logic        line_overrun
);

  localparam int c_PIX_W    = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;
  localparam int c_BLK_LAST = (H_ACTIVE / BLOCK_W) - 1;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    WAIT_LINE  = 2'd1,
    ACTIVE     = 2'd2
  } state_t;

  state_t             r_state;
  logic [79:0]        r_stage_key;
  logic [79:0]        r_active_key;
  logic [c_PIX_W-1:0] r_pix_cnt;
  logic [3:0]         r_blk_cnt;
  logic               r_line_done;
  logic [7:0]         w_key_byte [NUM_BLOCKS];

  for (genvar b = 0; b < NUM_BLOCKS; b++) begin : g_key_bytes
    assign w_key_byte[b] = r_active_key[8*b +: 8];
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= WAIT_FRAME;
      r_stage_key  <= '0;
      r_active_key <= '0;
      key_pending  <= 1'b0;
      r_pix_cnt    <= '0;
      r_blk_cnt    <= '0;
      r_line_done  <= 1'b0;
      shift_amt    <= '0;
      shift_valid  <= 1'b0;
      block_idx    <= '0;
      line_overrun <= 1'b0;
    end else begin
      shift_valid  <= 1'b0;
      line_overrun <= 1'b0;

      // A load coinciding with the frame boundary bypasses staging entirely.
      if (key_load && frame_start) begin
        r_stage_key  <= column_shift;
        r_active_key <= column_shift;
        key_pending  <= 1'b0;
      end else if (key_load) begin
        r_stage_key <= column_shift;
        key_pending <= 1'b1;
      end else if (frame_start && key_pending) begin
        r_active_key <= r_stage_key;
        key_pending  <= 1'b0;
      end

      if (frame_start) begin
        r_state     <= WAIT_LINE;
        r_pix_cnt   <= '0;
        r_blk_cnt   <= '0;
        r_line_done <= 1'b0;
      end else begin
        case (r_state)
          WAIT_FRAME: ;
          WAIT_LINE: begin
            if (line_start) begin
              r_state     <= ACTIVE;
              r_pix_cnt   <= '0;
              r_blk_cnt   <= '0;
              r_line_done <= 1'b0;
            end else if (pixel_valid && r_line_done) begin
              line_overrun <= 1'b1;
            end
          end
          ACTIVE: begin
            if (line_start) begin
              r_pix_cnt <= '0;
              r_blk_cnt <= '0;
            end else if (pixel_valid) begin
              shift_valid <= 1'b1;
              block_idx   <= r_blk_cnt;
              shift_amt   <= enable ? w_key_byte[r_blk_cnt] : 8'h00;
              if (r_pix_cnt == c_PIX_W'(BLOCK_W - 1)) begin
                r_pix_cnt <= '0;
                if (r_blk_cnt == 4'(c_BLK_LAST)) begin
                  r_state     <= WAIT_LINE;
                  r_blk_cnt   <= '0;
                  r_line_done <= 1'b1;
                end else begin
                  r_blk_cnt <= r_blk_cnt + 4'd1;
                end
              end else begin
                r_pix_cnt <= r_pix_cnt + 1'b1;
              end
            end
          end
          default: r_state <= WAIT_FRAME;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_column_shift_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_column_shift_scheduler
// Brief   : Directed self-checking bench for column_shift_scheduler.
// Revision: 1.0 - initial release
// ============================================================================
module tb_column_shift_scheduler;

  localparam logic [79:0] c_KEY_SEQ = 80'h0A090807060504030201;
  localparam logic [79:0] c_KEY_FF  = {10{8'hFF}};
  localparam logic [79:0] c_KEY_55  = {10{8'h55}};
  localparam logic [79:0] c_KEY_11  = {10{8'h11}};
  localparam logic [79:0] c_KEY_22  = {10{8'h22}};
  localparam logic [79:0] c_KEY_33  = {10{8'h33}};

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [79:0] column_shift;
  logic        key_load, enable, frame_start, line_start, pixel_valid;
  logic [7:0]  shift_amt;
  logic        shift_valid;
  logic [3:0]  block_idx;
  logic        key_pending;
  logic        line_overrun;

  int checks = 0;
  int failures = 0;

  column_shift_scheduler dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .column_shift (column_shift),
    .key_load     (key_load),
    .enable       (enable),
    .frame_start  (frame_start),
    .line_start   (line_start),
    .pixel_valid  (pixel_valid),
    .shift_amt    (shift_amt),
    .shift_valid  (shift_valid),
    .block_idx    (block_idx),
    .key_pending  (key_pending),
    .line_overrun (line_overrun)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
  endtask

  task automatic pulse_line();
    line_start = 1'b1; tick(); line_start = 1'b0;
  endtask

  task automatic load_key(input logic [79:0] k);
    column_shift = k; key_load = 1'b1; tick(); key_load = 1'b0;
  endtask

  task automatic send_pixels(input int n);
    pixel_valid = 1'b1;
    repeat (n) tick();
    pixel_valid = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; column_shift = '0; key_load = 0; enable = 1;
    frame_start = 0; line_start = 0; pixel_valid = 0;
    repeat (3) tick();
    checks++;
    if ({shift_valid, shift_amt, block_idx, key_pending, line_overrun} !== 15'd0) begin
      failures++;
      $display("FAIL reset_outputs: got sv=%0b amt=%h blk=%0d kp=%0b ov=%0b, want all 0",
               shift_valid, shift_amt, block_idx, key_pending, line_overrun);
    end
    Reset_n = 1'b1; tick();
    pulse_line();
    pixel_valid = 1'b1; tick(); pixel_valid = 1'b0;
    checks++;
    if (shift_valid !== 1'b0 || line_overrun !== 1'b0) begin
      failures++;
      $display("FAIL wait_frame_ignore: got sv=%0b ov=%0b, want 0 0", shift_valid, line_overrun);
    end
  endtask

  task automatic test_block_seq();
    int errs = 0;
    load_key(c_KEY_SEQ);
    checks++;
    if (key_pending !== 1'b1) begin
      failures++; $display("FAIL seq_pending_set: got %0b, want 1", key_pending);
    end
    pulse_frame();
    checks++;
    if (key_pending !== 1'b0) begin
      failures++; $display("FAIL seq_pending_clr: got %0b, want 0", key_pending);
    end
    pulse_line();
    enable = 1'b1;
    for (int p = 0; p < 640; p++) begin
      if (p % 50 == 25) begin
        pixel_valid = 1'b0; tick();
        checks++;
        if (shift_valid !== 1'b0) begin
          failures++; $display("FAIL seq_gap p=%0d: got sv=%0b, want 0", p, shift_valid);
        end
      end
      pixel_valid = 1'b1; tick();
      checks++;
      if (shift_valid !== 1'b1 || block_idx !== 4'(p / 64) || shift_amt !== 8'(p / 64 + 1)) begin
        failures++;
        if (errs++ < 5)
          $display("FAIL seq_pixel p=%0d: got sv=%0b blk=%0d amt=%h, want 1 %0d %h",
                   p, shift_valid, block_idx, shift_amt, p / 64, p / 64 + 1);
      end
    end
    pixel_valid = 1'b0; tick();
    checks++;
    if (shift_valid !== 1'b0) begin
      failures++; $display("FAIL seq_end_idle: got sv=%0b, want 0", shift_valid);
    end
  endtask

  task automatic test_enable_gate();
    pulse_line();
    for (int p = 0; p < 30; p++) begin
      enable = !(p >= 10 && p < 20);
      pixel_valid = 1'b1; tick();
      checks++;
      if (shift_valid !== 1'b1 || shift_amt !== (enable ? 8'h01 : 8'h00)) begin
        failures++;
        $display("FAIL enable_gate p=%0d: got sv=%0b amt=%h, want 1 %h",
                 p, shift_valid, shift_amt, enable ? 8'h01 : 8'h00);
      end
    end
    pixel_valid = 1'b0; enable = 1'b1;
  endtask

  task automatic test_overrun_restart();
    pulse_line();
    send_pixels(300);
    pulse_line();
    pixel_valid = 1'b1; tick();
    checks++;
    if (shift_valid !== 1'b1 || block_idx !== 4'd0 || shift_amt !== 8'h01) begin
      failures++;
      $display("FAIL restart_blk0: got sv=%0b blk=%0d amt=%h, want 1 0 01",
               shift_valid, block_idx, shift_amt);
    end
    send_pixels(638);
    pixel_valid = 1'b1; tick();
    checks++;
    if (shift_valid !== 1'b1 || block_idx !== 4'd9 || shift_amt !== 8'h0A) begin
      failures++;
      $display("FAIL last_pixel: got sv=%0b blk=%0d amt=%h, want 1 9 0a",
               shift_valid, block_idx, shift_amt);
    end
    tick();
    checks++;
    if (line_overrun !== 1'b1 || shift_valid !== 1'b0) begin
      failures++;
      $display("FAIL overrun_pulse: got ov=%0b sv=%0b, want 1 0", line_overrun, shift_valid);
    end
    pixel_valid = 1'b0; tick();
    checks++;
    if (line_overrun !== 1'b0) begin
      failures++; $display("FAIL overrun_single: got ov=%0b, want 0", line_overrun);
    end
  endtask

  task automatic test_double_buffer();
    pulse_line();
    send_pixels(10);
    load_key(c_KEY_FF);
    checks++;
    if (key_pending !== 1'b1) begin
      failures++; $display("FAIL dbuf_pending: got %0b, want 1", key_pending);
    end
    pixel_valid = 1'b1; tick(); pixel_valid = 1'b0;
    checks++;
    if (shift_amt !== 8'h01) begin
      failures++; $display("FAIL dbuf_old_key_line: got amt=%h, want 01", shift_amt);
    end
    pulse_line();
    send_pixels(200);
    pixel_valid = 1'b1; tick(); pixel_valid = 1'b0;
    checks++;
    if (shift_amt !== 8'h04 || block_idx !== 4'd3) begin
      failures++;
      $display("FAIL dbuf_old_key_next_line: got amt=%h blk=%0d, want 04 3", shift_amt, block_idx);
    end
    pulse_frame();
    checks++;
    if (key_pending !== 1'b0) begin
      failures++; $display("FAIL dbuf_pending_clr: got %0b, want 0", key_pending);
    end
    pulse_line();
    pixel_valid = 1'b1; tick(); pixel_valid = 1'b0;
    checks++;
    if (shift_valid !== 1'b1 || shift_amt !== 8'hFF) begin
      failures++; $display("FAIL dbuf_new_key: got sv=%0b amt=%h, want 1 ff", shift_valid, shift_amt);
    end
  endtask

  task automatic test_simul_load();
    column_shift = c_KEY_55; key_load = 1'b1; frame_start = 1'b1; tick();
    key_load = 1'b0; frame_start = 1'b0;
    checks++;
    if (key_pending !== 1'b0) begin
      failures++; $display("FAIL simul_pending: got %0b, want 0", key_pending);
    end
    pulse_line();
    pixel_valid = 1'b1; tick(); pixel_valid = 1'b0;
    checks++;
    if (shift_amt !== 8'h55) begin
      failures++; $display("FAIL simul_key: got amt=%h, want 55", shift_amt);
    end
    load_key(c_KEY_11);
    load_key(c_KEY_22);
    pulse_frame();
    pulse_line();
    pixel_valid = 1'b1; tick(); pixel_valid = 1'b0;
    checks++;
    if (shift_amt !== 8'h22 || key_pending !== 1'b0) begin
      failures++;
      $display("FAIL last_load_wins: got amt=%h kp=%0b, want 22 0", shift_amt, key_pending);
    end
  endtask

  task automatic test_reset_mid_active();
    load_key(c_KEY_33);
    pulse_line();
    send_pixels(100);
    pixel_valid = 1'b1;
    #1 Reset_n = 1'b0;
    #1;
    checks++;
    if ({shift_valid, shift_amt, block_idx, key_pending, line_overrun} !== 15'd0) begin
      failures++;
      $display("FAIL reset_async: got sv=%0b amt=%h blk=%0d kp=%0b ov=%0b, want all 0",
               shift_valid, shift_amt, block_idx, key_pending, line_overrun);
    end
    pixel_valid = 1'b0;
    tick(); tick();
    Reset_n = 1'b1; tick();
    pulse_line();
    pixel_valid = 1'b1; tick(); pixel_valid = 1'b0;
    checks++;
    if (shift_valid !== 1'b0) begin
      failures++; $display("FAIL reset_wait_frame: got sv=%0b, want 0", shift_valid);
    end
    pulse_frame();
    pulse_line();
    pixel_valid = 1'b1; tick(); pixel_valid = 1'b0;
    checks++;
    if (shift_valid !== 1'b1 || shift_amt !== 8'h00 || block_idx !== 4'd0) begin
      failures++;
      $display("FAIL reset_key_zero: got sv=%0b amt=%h blk=%0d, want 1 00 0",
               shift_valid, shift_amt, block_idx);
    end
  endtask

  initial begin
    test_reset();
    test_block_seq();
    test_enable_gate();
    test_overrun_restart();
    test_double_buffer();
    test_simul_load();
    test_reset_mid_active();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
